// File: rtl/dmem_demux_if.sv
// Bus bundle between the CPU memory stage, dmem_demux and its four targets.
// The slave modport is the demux's own view; the master modport is the view
// of everything around it (CPU request side plus the target responses).
interface dmem_demux_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_ready;
  logic             cpu_err;
  logic [3:0]       s_en;
  logic             s_we;
  logic [WIDTH-1:0] s_addr;
  logic [WIDTH-1:0] s_wdata;
  logic [WIDTH-1:0] s0_rdata;
  logic [WIDTH-1:0] s1_rdata;
  logic [WIDTH-1:0] s2_rdata;
  logic [WIDTH-1:0] s3_rdata;
  logic [3:0]       s_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_err,
    output s_en, s_we, s_addr, s_wdata,
    input  s0_rdata, s1_rdata, s2_rdata, s3_rdata, s_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_err,
    input  s_en, s_we, s_addr, s_wdata,
    output s0_rdata, s1_rdata, s2_rdata, s3_rdata, s_ack
  );
endinterface

// File: rtl/dmem_demux.sv
// Data-memory access steering: routes one CPU load/store to RAM, timer, GPIO
// or UART (address bits [29:28]), waits for that target's ack or a timeout,
// and returns registered read data with a one-cycle completion pulse.
module dmem_demux #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input logic         clk,
  input logic         rst,
  dmem_demux_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [1:0]       sel;
  logic [7:0]       count;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic [WIDTH-1:0] sel_rdata;
  logic             ack_sel;
  logic             timeout_hit;

  // Only the selected target's ack and read data matter during an access.
  always_comb begin
    sel_rdata = bus.s0_rdata;
    case (sel)
      2'd0:    sel_rdata = bus.s0_rdata;
      2'd1:    sel_rdata = bus.s1_rdata;
      2'd2:    sel_rdata = bus.s2_rdata;
      default: sel_rdata = bus.s3_rdata;
    endcase
  end

  assign ack_sel     = bus.s_ack[sel];
  assign timeout_hit = (count == LAST_COUNT);

  // Next-state logic; an ack on the timeout edge still ends the access normally.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.cpu_req) state_next = ACCESS;
      ACCESS:  if (ack_sel || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request latching, timeout counting and completion data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= 2'd0;
      count   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            sel     <= bus.cpu_addr[29:28];
            count   <= 8'd0;
          end
        end
        ACCESS: begin
          if (ack_sel) begin
            rdata_q <= we_q ? '0 : sel_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so nothing flows straight from inputs.
  assign bus.s_en      = (state == ACCESS) ? (4'b0001 << sel) : 4'b0000;
  assign bus.cpu_ready = (state == DONE);
  assign bus.s_we      = we_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_err   = err_q;

endmodule

// File: tb/tb_dmem_demux.sv
// Self-checking bench for dmem_demux: directed scenarios plus randomized
// transactions, with expectations derived from a transaction-level model.
module tb_dmem_demux;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   edge_cnt = 0;
  int   accept_edge;
  logic [31:0] rd [4];

  dmem_demux_if #(.WIDTH(WIDTH)) bus ();

  dmem_demux #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock and an edge counter used to measure request spacing.
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. delay is the ACCESS cycle (1-based) in which the
  // selected target acks; values outside 1..TIMEOUT mean it never acks.
  // noise is ORed onto the unselected ack bits every cycle. hold keeps cpu_req
  // high past acceptance. Starts and ends #1 after an edge with the DUT in IDLE.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [3:0] noise, input logic hold);
    logic [1:0]  tgt;
    logic [3:0]  mask;
    logic        exp_err;
    int          exp_len;
    logic [31:0] exp_rdata;
    tgt  = addr[29:28];
    mask = 4'b0001 << tgt;
    exp_err   = !(delay >= 1 && delay <= TIMEOUT);
    exp_len   = exp_err ? TIMEOUT : delay;
    exp_rdata = (exp_err || we) ? 32'h0 : rd[tgt];

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.s0_rdata  = rd[0];
    bus.s1_rdata  = rd[1];
    bus.s2_rdata  = rd[2];
    bus.s3_rdata  = rd[3];
    bus.s_ack     = 4'b0000;
    tick();
    accept_edge = edge_cnt;
    bus.cpu_req = hold;
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;

    for (int i = 1; i <= exp_len; i++) begin
      check("s_en_access", {28'h0, bus.s_en}, {28'h0, mask});
      check("ready_access", {31'h0, bus.cpu_ready}, 32'h0);
      check("s_addr_stable", bus.s_addr, addr);
      check("s_wdata_stable", bus.s_wdata, wdata);
      check("s_we_stable", {31'h0, bus.s_we}, {31'h0, we});
      bus.s_ack = ((i == delay) ? mask : 4'b0000) | (noise & ~mask);
      tick();
    end

    check("ready_done", {31'h0, bus.cpu_ready}, 32'h1);
    check("s_en_done", {28'h0, bus.s_en}, 32'h0);
    check("err_done", {31'h0, bus.cpu_err}, {31'h0, exp_err});
    check("rdata_done", bus.cpu_rdata, exp_rdata);
    bus.s_ack = 4'b0000;
    tick();

    check("ready_idle", {31'h0, bus.cpu_ready}, 32'h0);
    check("s_en_idle", {28'h0, bus.s_en}, 32'h0);
    check("s_addr_hold", bus.s_addr, addr);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int first_edge;

    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h3000_00AC; bus.cpu_wdata = 32'hDEAD_BEEF;
    bus.s0_rdata = '0; bus.s1_rdata = '0; bus.s2_rdata = '0; bus.s3_rdata = '0;
    bus.s_ack = 4'b1111;
    for (int i = 0; i < 4; i++) rd[i] = $urandom;

    // Reset held for two edges with a request pending.
    rst = 1'b1;
    tick();
    tick();
    check("rst_s_en", {28'h0, bus.s_en}, 32'h0);
    check("rst_ready", {31'h0, bus.cpu_ready}, 32'h0);
    check("rst_err", {31'h0, bus.cpu_err}, 32'h0);
    check("rst_rdata", bus.cpu_rdata, 32'h0);
    check("rst_s_we", {31'h0, bus.s_we}, 32'h0);
    check("rst_s_addr", bus.s_addr, 32'h0);
    check("rst_s_wdata", bus.s_wdata, 32'h0);
    rst = 1'b0;

    // Load from target 2, acked in the first ACCESS cycle.
    rd[2] = 32'hCAFE_F00D;
    do_txn(1'b0, 32'h2000_0010, 32'h0, 1, 4'b0000, 1'b0);

    // Store to target 0 with a 3-cycle ack delay.
    do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 3, 4'b0000, 1'b0);

    // Target 3 never acks, then acks exactly on the last allowed cycle.
    do_txn(1'b0, 32'h3000_0000, 32'h0, 0, 4'b0000, 1'b0);
    do_txn(1'b0, 32'h3000_0008, 32'h0, TIMEOUT, 4'b0000, 1'b0);

    // Target 1 with a stray ack from target 0 on every cycle.
    do_txn(1'b0, 32'h1000_0020, 32'h0, 4, 4'b0001, 1'b0);
    do_txn(1'b0, 32'h1000_0024, 32'h0, TIMEOUT + 1, 4'b1101, 1'b0);

    // Reset in the middle of an access aborts it without a ready pulse.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h3000_0040;
    bus.s_ack = 4'b0000;
    tick();
    bus.cpu_req = 1'b0;
    check("abort_s_en", {28'h0, bus.s_en}, 32'h8);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_s_en_off", {28'h0, bus.s_en}, 32'h0);
    check("abort_ready", {31'h0, bus.cpu_ready}, 32'h0);
    tick();
    check("abort_ready2", {31'h0, bus.cpu_ready}, 32'h0);

    // Request held through DONE: accepted again exactly 3 edges later.
    do_txn(1'b0, 32'h0000_0100, 32'h0, 1, 4'b0000, 1'b1);
    first_edge = accept_edge;
    do_txn(1'b1, 32'h2000_0200, 32'h5555_AAAA, 1, 4'b0000, 1'b1);
    check("b2b_spacing", 32'(accept_edge - first_edge), 32'd3);
    do_txn(1'b0, 32'h1000_0300, 32'h0, 2, 4'b0000, 1'b0);

    // Randomized traffic across targets, delays, timeouts and ack noise.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) rd[i] = $urandom;
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, TIMEOUT + 2)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_demux.md
# dmem_demux

Data-memory access steering block for the MIPS core. It takes a single load/store request from the CPU memory stage and routes it to one of four targets, selected by address bits [29:28]: data RAM, timer, GPIO or UART. It then waits for that target's acknowledge, or for a timeout, and returns registered read data and a one-cycle completion pulse. It is the fan-out counterpart of the core's select-one-of-four result muxes.

## Interface
Parameters:
- WIDTH, 32, data and address width.
- TIMEOUT, 8, maximum cycles spent in ACCESS before the request is forced to complete with an error; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load; latched with cpu_req.
- cpu_addr  in  WIDTH  byte address; latched with cpu_req.
- cpu_wdata  in  WIDTH  store data; latched with cpu_req.
- cpu_rdata  out  WIDTH  registered load data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  timeout flag; valid while cpu_ready=1.
- s_en  out  4  one-hot target enable, bit n selects target n.
- s_we  out  1  latched write enable, shared by all targets.
- s_addr  out  WIDTH  latched address, shared.
- s_wdata  out  WIDTH  latched store data, shared.
- s0_rdata..s3_rdata  in  WIDTH each  target read data.
- s_ack  in  4  per-target acknowledge, bit n from target n.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, cpu_req=1 at the edge:
  - latch cpu_we, cpu_addr and cpu_wdata into the s_* registers.
  - sel = cpu_addr[29:28].
  - clear the timeout counter.
  - go to ACCESS.
- IDLE, cpu_req=0: stay in IDLE.
- ACCESS:
  - s_en = 1 << sel; all other s_en bits are 0.
  - Only s_ack[sel] is observed; acks from unselected targets are ignored.
- ACCESS, s_ack[sel]=1 at the edge:
  - loads: cpu_rdata <= s{sel}_rdata.
  - stores: cpu_rdata <= 0.
  - cpu_err <= 0.
  - go to DONE.
- ACCESS, no ack at the edge:
  - the counter increments.
  - When the counter equals TIMEOUT-1 at an edge with no ack: cpu_rdata <= 0, cpu_err <= 1, go to DONE.
  - An ack arriving on the same edge as the timeout takes priority: normal completion, err=0.
- DONE:
  - cpu_ready=1 and s_en=0.
  - Unconditionally return to IDLE on the next edge.
  - cpu_req is not sampled in DONE.
- cpu_req asserted during ACCESS or DONE is ignored and is not queued. The CPU holds its request until it sees cpu_ready, then deasserts or re-presents it.
- Counter width is 8 bits. It never wraps, because the timeout fires first.

## Timing
- Reset values, applied one edge after rst=1 is sampled:
  - state=IDLE
  - s_en=0, s_we=0, s_addr=0, s_wdata=0
  - cpu_rdata=0, cpu_ready=0, cpu_err=0
  - counter=0
- Reset mid-ACCESS or mid-DONE aborts the transaction: no cpu_ready pulse and s_en drops at the next edge.
- cpu_req sampled at edge k gives s_en high from cycle k+1.
- First ack sampled at edge k+1 gives cpu_ready high in cycle k+2. This is the minimum latency of 2 cycles from request to ready.
- Ack sampled at edge m gives cpu_ready high in cycle m+1, for exactly one cycle.
- Timeout: s_en is high for exactly TIMEOUT cycles, and cpu_ready is high in the following cycle.
- Back-to-back requests:
  - minimum spacing of accepted requests is 3 edges.
  - a request held high through DONE is accepted at the first edge in IDLE.
- The s_* outputs are stable for the whole ACCESS state.
- s_we, s_addr and s_wdata hold their last values in IDLE and DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst=1 for 2 cycles with cpu_req=1 -> all outputs 0 and state IDLE. Release rst -> request accepted at the first edge.
- Load from target 2: cpu_addr=0x2000_0010, s2_rdata=0xCAFE_F00D, s_ack[2] high in the first ACCESS cycle -> s_en=4'b0100 for 1 cycle, then cpu_ready=1 with cpu_rdata=0xCAFE_F00D and cpu_err=0, 2 cycles after the request.
- Store to target 0 with a 3-cycle ack delay: cpu_we=1, addr=0x0000_0004, wdata=0x1234_5678 -> s_en=4'b0001 for 3 cycles, s_wdata stable, then cpu_ready with cpu_rdata=0.
- Timeout: target 3 selected, never acks, TIMEOUT=8 -> s_en=4'b1000 for exactly 8 cycles, then cpu_ready=1, cpu_err=1, cpu_rdata=0. Ack on the 8th cycle instead -> cpu_err=0.
- Wrong-target ack: target 1 selected, s_ack=4'b0001 pulsed -> ignored. Completion happens only on s_ack[1].
- Reset mid-ACCESS, then a held cpu_req across DONE -> no cpu_ready after reset. Consecutive accepted requests are exactly 3 edges apart.
